pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the five-stage core. Merges per-stage stall requests into the six-bit stall vector and sequences exception and ERET redirects into a one-cycle freeze, then a one-cycle flush with a new PC. Also runs a stall watchdog. It sits beside the IF/ID/EX/MEM/WB stages and drives every pipeline register's stall/flush input and the PC redirect port.

## Interface
- EXC_VECTOR, 32'h0000_0020, PC loaded on exception redirect
- TIMEOUT, 1024, consecutive stalled cycles before watchdog fires (≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- stallreq_if  in  1  instruction fetch waiting on bus
- stallreq_id  in  1  load-use hazard in decode
- stallreq_ex  in  1  multi-cycle EX op busy
- stallreq_mem  in  1  data bus waiting
- excp_valid  in  1  exception pending on the instruction in MEM, held until flush
- eret_valid  in  1  ERET in MEM, held until flush
- epc_i  in  32  return address for ERET
- stall  out  6  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
- flush  out  1  clear all pipeline registers
- new_pc  out  32  redirect target, valid with new_pc_valid
- new_pc_valid  out  1  load new_pc into PC this cycle
- stall_timeout  out  1  sticky watchdog flag
- busy  out  1  FSM not in RUN

## Operation
- States: RUN, FREEZE, FLUSH. Reset → RUN; all outputs 0, new_pc = 0, counters 0.
- RUN, stall vector, priority mem > ex > id > if: mem → 6'b011111; ex → 6'b001111; id → 6'b000111; if → 6'b000011; none → 6'b000000. Vector is combinational from requests.
- RUN, redirect accepted when (excp_valid | eret_valid) & ~stallreq_mem. Target registered: excp_valid → EXC_VECTOR, else epc_i. Both high → exception wins. Next state FREEZE.
- If stallreq_mem is high, the redirect waits in RUN with the normal stall vector.
- FREEZE (1 cycle): stall = 6'b111111, flush = 0. Next state FLUSH.
- FLUSH (1 cycle): stall = 0, flush = 1, new_pc_valid = 1, new_pc = registered target. Next state RUN.
- Stall requests are ignored in FREEZE and FLUSH.
- Requests still high in the first RUN cycle after FLUSH are serviced normally. Upstream must drop excp/eret on flush.
- busy = 1 in FREEZE and FLUSH.
- new_pc holds its last value when new_pc_valid = 0.
- Watchdog:
  - 16-bit counter increments each RUN cycle with stall[0] = 1 and clears on any cycle with stall[0] = 0.
  - When the counter reaches TIMEOUT, stall_timeout sets and stays set until rst. The counter saturates there.
  - Stalls are not released by the watchdog.

## Timing
- Stall vector: zero-latency, same cycle as the request.
- Redirect, acceptance in cycle N: freeze in N+1, flush and new_pc_valid in N+2, PC fetches target in N+3.
- Reset mid-sequence (FREEZE or FLUSH): next cycle RUN, flush = 0, new_pc_valid = 0, target discarded.
- stall_timeout asserts the cycle after the TIMEOUT-th consecutive stalled cycle.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cnt (32 bits) and perf_flush_cnt (16 bits).
  - perf_stall_cnt increments on each RUN cycle with stall ≠ 0.
  - perf_flush_cnt increments on each FLUSH cycle.
  - Both wrap modulo 2^width and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Priority: stallreq_id = 1 and stallreq_ex = 1 in the same cycle → stall = 6'b001111 that cycle; drop ex → 6'b000111.
- Exception: excp_valid = 1 at cycle N, no mem stall → stall = 6'b111111 at N+1; flush = 1, new_pc_valid = 1, new_pc = 32'h20 at N+2; RUN at N+3.
- Deferred redirect: eret_valid = 1 with epc_i = 32'h0000_1234 while stallreq_mem = 1 for 5 cycles → stall = 6'b011111 for 5 cycles, then freeze, then flush with new_pc = 32'h1234.
- Simultaneous: excp_valid = 1 and eret_valid = 1 → new_pc = EXC_VECTOR.
- Watchdog: TIMEOUT = 8, stallreq_if held 8 cycles → stall_timeout = 1 on the 9th cycle and remains 1 after stall drops. A 7-cycle stall → stays 0.
- Reset: rst asserted during FREEZE → next cycle RUN, all outputs 0, no flush pulse. With PIPE_CTRL_PERF_EN, perf_stall_cnt = 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Stall/flush/redirect bundle between the pipeline stages (master) and pipe_ctrl (slave).
// PIPE_CTRL_PERF_EN adds the performance counter outputs.
interface pipe_ctrl_if;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        excp_valid;
   logic        eret_valid;
   logic [31:0] epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        new_pc_valid;
   logic        stall_timeout;
   logic        busy;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [15:0] perf_flush_cnt;
`endif

   modport master (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output excp_valid, eret_valid, epc_i,
      input  stall, flush, new_pc, new_pc_valid, stall_timeout, busy
`ifdef PIPE_CTRL_PERF_EN
      , input perf_stall_cnt, perf_flush_cnt
`endif
   );

   modport slave (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  excp_valid, eret_valid, epc_i,
      output stall, flush, new_pc, new_pc_valid, stall_timeout, busy
`ifdef PIPE_CTRL_PERF_EN
      , output perf_stall_cnt, perf_flush_cnt
`endif
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall-vector merge, exception/ERET freeze+flush redirect, stall watchdog.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter int unsigned TIMEOUT    = 1024
) (
   input logic         clk,
   input logic         rst,
   pipe_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {RUN, FREEZE, FLUSH} state_e;

   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

   state_e      state_q;
   logic [31:0] target_q;
   logic [31:0] new_pc_q;
   logic        flush_q;
   logic        new_pc_valid_q;
   logic        busy_q;
   logic [15:0] wd_cnt_q, wd_cnt_d;
   logic        timeout_q;
   logic [5:0]  stall_run;
   logic [5:0]  stall_c;
   logic        redirect;

   always_comb begin
      stall_run = '0;
      if (bus.stallreq_mem)     stall_run = 6'b011111;
      else if (bus.stallreq_ex) stall_run = 6'b001111;
      else if (bus.stallreq_id) stall_run = 6'b000111;
      else if (bus.stallreq_if) stall_run = 6'b000011;
   end

   always_comb begin
      stall_c = '0;
      case (state_q)
         RUN:     stall_c = stall_run;
         FREEZE:  stall_c = '1;
         default: stall_c = '0;
      endcase
   end

   // A memory stall holds off the redirect so the faulting instruction's bus access completes.
   assign redirect = (state_q == RUN) & (bus.excp_valid | bus.eret_valid) & ~bus.stallreq_mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         target_q       <= '0;
         new_pc_q       <= '0;
         flush_q        <= 1'b0;
         new_pc_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (redirect) begin
                  target_q <= bus.excp_valid ? EXC_VECTOR : bus.epc_i;
                  state_q  <= FREEZE;
                  busy_q   <= 1'b1;
               end
            end
            FREEZE: begin
               state_q        <= FLUSH;
               flush_q        <= 1'b1;
               new_pc_valid_q <= 1'b1;
               new_pc_q       <= target_q;
            end
            default: begin
               state_q        <= RUN;
               flush_q        <= 1'b0;
               new_pc_valid_q <= 1'b0;
               busy_q         <= 1'b0;
            end
         endcase
      end
   end

   // Counts only RUN stalls; FREEZE holds the count, FLUSH (stall = 0) clears it.
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (!stall_c[0])
         wd_cnt_d = '0;
      else if (state_q == RUN && wd_cnt_q != TIMEOUT_W)
         wd_cnt_d = wd_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_q | (wd_cnt_d == TIMEOUT_W);
      end
   end

   assign bus.stall         = stall_c;
   assign bus.flush         = flush_q;
   assign bus.new_pc        = new_pc_q;
   assign bus.new_pc_valid  = new_pc_valid_q;
   assign bus.stall_timeout = timeout_q;
   assign bus.busy          = busy_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q;
   logic [15:0] perf_flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (state_q == RUN && stall_c != '0) perf_stall_q <= perf_stall_q + 32'd1;
         if (state_q == FLUSH)                perf_flush_q <= perf_flush_q + 16'd1;
      end
   end

   assign bus.perf_stall_cnt = perf_stall_q;
   assign bus.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors with hand-computed expectations.
// Uses TIMEOUT = 8 so the watchdog boundary is reachable quickly.
module tb_pipe_ctrl;

   logic clk;
   logic rst;
   pipe_ctrl_if bus ();

   pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [5:0]  stall;
      logic        flush;
      logic        npv;
      logic [31:0] pc;
      logic        to;
      logic        busy;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;

   // Drive one cycle of inputs just after the edge and queue that cycle's expected outputs.
   task automatic step(input string name, input logic r, input logic [3:0] req,
                       input logic ex, input logic er, input logic [31:0] epc,
                       input logic [5:0] s, input logic f, input logic v,
                       input logic [31:0] pc, input logic to, input logic b);
      exp_t e;
      @(posedge clk);
      #1;
      rst              = r;
      bus.stallreq_mem = req[3];
      bus.stallreq_ex  = req[2];
      bus.stallreq_id  = req[1];
      bus.stallreq_if  = req[0];
      bus.excp_valid   = ex;
      bus.eret_valid   = er;
      bus.epc_i        = epc;
      e.name = name; e.stall = s; e.flush = f; e.npv = v; e.pc = pc; e.to = to; e.busy = b;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         vectors++;
         if (bus.stall !== e.stall || bus.flush !== e.flush || bus.new_pc_valid !== e.npv ||
             bus.new_pc !== e.pc || bus.stall_timeout !== e.to || bus.busy !== e.busy) begin
            errors++;
            $display("FAIL %s (t=%0t): got stall=%b flush=%b npv=%b pc=%h to=%b busy=%b, want stall=%b flush=%b npv=%b pc=%h to=%b busy=%b",
                     e.name, $time, bus.stall, bus.flush, bus.new_pc_valid, bus.new_pc,
                     bus.stall_timeout, bus.busy, e.stall, e.flush, e.npv, e.pc, e.to, e.busy);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: simulation did not finish within time limit");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1;
      bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b0;
      bus.stallreq_mem = 1'b0; bus.excp_valid = 1'b0; bus.eret_valid = 1'b0;
      bus.epc_i = '0;

      // reset state
      step("reset0", 1, 4'b0000, 0, 0, 32'h0, 6'b000000, 0, 0, 32'h0, 0, 0);
      step("reset1", 0, 4'b0000, 0, 0, 32'h0, 6'b000000, 0, 0, 32'h0, 0, 0);

      // stall priority: mem > ex > id > if
      step("prio_id_ex", 0, 4'b0110, 0, 0, 32'h0, 6'b001111, 0, 0, 32'h0, 0, 0);
      step("prio_id",    0, 4'b0010, 0, 0, 32'h0, 6'b000111, 0, 0, 32'h0, 0, 0);
      step("prio_if",    0, 4'b0001, 0, 0, 32'h0, 6'b000011, 0, 0, 32'h0, 0, 0);
      step("prio_mem",   0, 4'b1111, 0, 0, 32'h0, 6'b011111, 0, 0, 32'h0, 0, 0);
      step("prio_none",  0, 4'b0000, 0, 0, 32'h0, 6'b000000, 0, 0, 32'h0, 0, 0);

      // exception redirect; stall requests ignored in FREEZE/FLUSH
      step("exc_accept", 0, 4'b0000, 1, 0, 32'h0, 6'b000000, 0, 0, 32'h0,  0, 0);
      step("exc_freeze", 0, 4'b0010, 1, 0, 32'h0, 6'b111111, 0, 0, 32'h0,  0, 1);
      step("exc_flush",  0, 4'b1000, 1, 0, 32'h0, 6'b000000, 1, 1, 32'h20, 0, 1);
      step("exc_run",    0, 4'b0000, 0, 0, 32'h0, 6'b000000, 0, 0, 32'h20, 0, 0);

      // ERET deferred by a 5-cycle memory stall, accepted alongside an EX stall
      for (int i = 0; i < 5; i++)
         step("eret_defer", 0, 4'b1000, 0, 1, 32'h1234, 6'b011111, 0, 0, 32'h20, 0, 0);
      step("eret_accept", 0, 4'b0100, 0, 1, 32'h1234, 6'b001111, 0, 0, 32'h20,   0, 0);
      step("eret_freeze", 0, 4'b0000, 0, 1, 32'h1234, 6'b111111, 0, 0, 32'h20,   0, 1);
      step("eret_flush",  0, 4'b0000, 0, 1, 32'h1234, 6'b000000, 1, 1, 32'h1234, 0, 1);
      step("eret_run",    0, 4'b0000, 0, 0, 32'h0,    6'b000000, 0, 0, 32'h1234, 0, 0);

      // exception wins over simultaneous ERET
      step("both_accept", 0, 4'b0000, 1, 1, 32'hDEAD_BEEF, 6'b000000, 0, 0, 32'h1234, 0, 0);
      step("both_freeze", 0, 4'b0000, 1, 1, 32'hDEAD_BEEF, 6'b111111, 0, 0, 32'h1234, 0, 1);
      step("both_flush",  0, 4'b0000, 1, 1, 32'hDEAD_BEEF, 6'b000000, 1, 1, 32'h20,   0, 1);
      step("both_run",    0, 4'b0000, 0, 0, 32'h0,         6'b000000, 0, 0, 32'h20,   0, 0);

      // reset during FREEZE discards the redirect
      step("rstfz_accept", 0, 4'b0000, 0, 1, 32'h5555_0000, 6'b000000, 0, 0, 32'h20, 0, 0);
      step("rstfz_freeze", 1, 4'b0000, 0, 1, 32'h5555_0000, 6'b111111, 0, 0, 32'h20, 0, 1);
      step("rstfz_after",  0, 4'b0000, 0, 0, 32'h0,         6'b000000, 0, 0, 32'h0,  0, 0);
`ifdef PIPE_CTRL_PERF_EN
      #2;
      vectors++;
      if (bus.perf_stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL perf_after_reset: got perf_stall_cnt=%0d, want 0", bus.perf_stall_cnt);
      end
`endif
      step("rstfz_idle",   0, 4'b0000, 0, 0, 32'h0,         6'b000000, 0, 0, 32'h0,  0, 0);

      // watchdog: 7 stalled cycles must not fire
      for (int i = 0; i < 7; i++)
         step("wd7_stall", 0, 4'b0001, 0, 0, 32'h0, 6'b000011, 0, 0, 32'h0, 0, 0);
      step("wd7_gap", 0, 4'b0000, 0, 0, 32'h0, 6'b000000, 0, 0, 32'h0, 0, 0);

      // 8 stalled cycles fire on the 9th and stay sticky
      for (int i = 0; i < 8; i++)
         step("wd8_stall", 0, 4'b0001, 0, 0, 32'h0, 6'b000011, 0, 0, 32'h0, 0, 0);
      step("wd8_fire",   0, 4'b0000, 0, 0, 32'h0, 6'b000000, 0, 0, 32'h0, 1, 0);
      step("wd8_sticky", 0, 4'b0010, 0, 0, 32'h0, 6'b000111, 0, 0, 32'h0, 1, 0);
      step("wd8_hold",   0, 4'b0000, 0, 0, 32'h0, 6'b000000, 0, 0, 32'h0, 1, 0);

      // only reset clears the sticky flag
      step("wd_rst",   1, 4'b0000, 0, 0, 32'h0, 6'b000000, 0, 0, 32'h0, 1, 0);
      step("wd_clear", 0, 4'b0000, 0, 0, 32'h0, 6'b000000, 0, 0, 32'h0, 0, 0);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending vectors, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
